// File: rtl/color_mapper_pkg.sv
// Shared types and constants for the multi-object VGA colour mapper.
package color_mapper_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        SHAPE_CIRCLE = 1'b0,
        SHAPE_SQUARE = 1'b1
    } shape_e;

    localparam int unsigned PALETTE_N = 8;

    localparam rgb_t PALETTE [0:PALETTE_N-1] = '{
        '{r: 8'hFF, g: 8'h55, b: 8'h00},
        '{r: 8'h00, g: 8'hFF, b: 8'h55},
        '{r: 8'h55, g: 8'h00, b: 8'hFF},
        '{r: 8'hFF, g: 8'hFF, b: 8'h00},
        '{r: 8'h00, g: 8'hFF, b: 8'hFF},
        '{r: 8'hFF, g: 8'h00, b: 8'hFF},
        '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
        '{r: 8'h80, g: 8'h80, b: 8'h80}
    };

    localparam logic [7:0] BG_BLUE_BASE = 8'h7F;

endpackage

// File: rtl/multi_obj_color_mapper_obj_hit_test.sv
// Per-object hit test: S1 registers signed deltas, S2 registers the coverage decision.
module obj_hit_test
    import color_mapper_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SIZE_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [SIZE_W-1:0]  obj_size,
    input  logic               obj_shape,
    input  logic               obj_en,
    output logic               hit
);

    localparam int unsigned DW  = COORD_W + 1;
    localparam int unsigned SQW = 2 * COORD_W + 2;

    logic signed [DW-1:0] dx_q;
    logic signed [DW-1:0] dy_q;
    logic [SIZE_W-1:0]    size_q;
    shape_e               shape_q;
    logic                 en_q;

    logic [DW-1:0]        mag_x;
    logic [DW-1:0]        mag_y;
    logic [SQW-1:0]       dist2;
    logic [SQW-1:0]       size2;
    logic                 circ_hit;
    logic                 sq_hit;
    logic                 hit_c;

    // S1: signed deltas so objects hanging off either screen edge still compare correctly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q    <= '0;
            dy_q    <= '0;
            size_q  <= '0;
            shape_q <= SHAPE_CIRCLE;
            en_q    <= 1'b0;
        end else begin
            dx_q    <= $signed({1'b0, draw_x}) - $signed({1'b0, obj_x});
            dy_q    <= $signed({1'b0, draw_y}) - $signed({1'b0, obj_y});
            size_q  <= obj_size;
            shape_q <= shape_e'(obj_shape);
            en_q    <= obj_en;
        end
    end

    // S2 combinational: magnitudes, squared distance and shape selection
    always_comb begin
        mag_x    = dx_q[DW-1] ? DW'(-dx_q) : DW'(dx_q);
        mag_y    = dy_q[DW-1] ? DW'(-dy_q) : DW'(dy_q);
        dist2    = SQW'(mag_x) * SQW'(mag_x) + SQW'(mag_y) * SQW'(mag_y);
        size2    = SQW'(size_q) * SQW'(size_q);
        circ_hit = (dist2 <= size2);
        sq_hit   = (mag_x <= DW'(size_q)) && (mag_y <= DW'(size_q));
        hit_c    = en_q && ((shape_q == SHAPE_SQUARE) ? sq_hit : circ_hit);
    end

    // S2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_c;
        end
    end

endmodule

// File: rtl/multi_obj_color_mapper.sv
// Pixel colour generator: frame-latched object shadows, per-object hit pipeline,
// lowest-index priority and palette / background-gradient colour selection.
module multi_obj_color_mapper
    import color_mapper_pkg::*;
#(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SIZE_W  = 6,
    localparam int unsigned IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       frame_start,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*SIZE_W-1:0]  obj_size,
    input  logic [NUM_OBJ-1:0]         obj_shape,
    input  logic [NUM_OBJ-1:0]         obj_en,
    input  logic                       pixel_valid,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    output logic                       out_valid,
    output logic [7:0]                 Red,
    output logic [7:0]                 Green,
    output logic [7:0]                 Blue,
    output logic                       hit,
    output logic [IDX_W-1:0]           hit_idx
);

    localparam int unsigned BW = COORD_W + 8;

    logic [NUM_OBJ*COORD_W-1:0] sh_x;
    logic [NUM_OBJ*COORD_W-1:0] sh_y;
    logic [NUM_OBJ*SIZE_W-1:0]  sh_size;
    logic [NUM_OBJ-1:0]         sh_shape;
    logic [NUM_OBJ-1:0]         sh_en;

    logic                       v1_q;
    logic                       v2_q;
    logic [COORD_W-1:0]         x1_q;
    logic [COORD_W-1:0]         x2_q;

    logic [NUM_OBJ-1:0]         hit_vec;
    logic                       win_hit;
    logic [IDX_W-1:0]           win_idx;
    logic [COORD_W-1:0]         x_shift;
    logic [7:0]                 bg_blue;
    rgb_t                       pix_rgb;

    // Object shadow registers, refreshed only at frame start so objects never tear mid-frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_size  <= '0;
            sh_shape <= '0;
            sh_en    <= '0;
        end else if (frame_start) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_size  <= obj_size;
            sh_shape <= obj_shape;
            sh_en    <= obj_en;
        end
    end

    // One hit tester per object
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        obj_hit_test #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_hit (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .obj_x     (sh_x[g*COORD_W +: COORD_W]),
            .obj_y     (sh_y[g*COORD_W +: COORD_W]),
            .obj_size  (sh_size[g*SIZE_W +: SIZE_W]),
            .obj_shape (sh_shape[g]),
            .obj_en    (sh_en[g]),
            .hit       (hit_vec[g])
        );
    end

    // Valid and DrawX follow the hit pipeline through S1 and S2
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            v1_q <= pixel_valid;
            v2_q <= v1_q;
            x1_q <= DrawX;
            x2_q <= x1_q;
        end
    end

    // Lowest-index priority encoder plus colour selection
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        x_shift = x2_q >> 3;
        bg_blue = (BW'(x_shift) > BW'(BG_BLUE_BASE)) ? 8'h00
                                                      : BG_BLUE_BASE - 8'(x_shift);
        pix_rgb = win_hit ? PALETTE[3'(win_idx)] : '{r: 8'h00, g: 8'h00, b: bg_blue};
    end

    // S3 output register; payload holds while no pixel is emerging
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                Red     <= pix_rgb.r;
                Green   <= pix_rgb.g;
                Blue    <= pix_rgb.b;
                hit     <= win_hit;
                hit_idx <= win_hit ? win_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_multi_obj_color_mapper.sv
// Scoreboard bench for multi_obj_color_mapper: an independent pixel model predicts
// each output when the pixel is driven; the monitor compares when out_valid rises.
module tb_multi_obj_color_mapper;

    localparam int unsigned NUM_OBJ = 4;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned SIZE_W  = 6;
    localparam int unsigned IDX_W   = 2;
    localparam int          LAT     = 3;

    typedef struct {
        int         cyc;
        logic       hit;
        logic [1:0] idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic                       Clk;
    logic                       Reset_n;
    logic                       frame_start;
    logic [NUM_OBJ*COORD_W-1:0] obj_x;
    logic [NUM_OBJ*COORD_W-1:0] obj_y;
    logic [NUM_OBJ*SIZE_W-1:0]  obj_size;
    logic [NUM_OBJ-1:0]         obj_shape;
    logic [NUM_OBJ-1:0]         obj_en;
    logic                       pixel_valid;
    logic [COORD_W-1:0]         DrawX;
    logic [COORD_W-1:0]         DrawY;
    logic                       out_valid;
    logic [7:0]                 Red;
    logic [7:0]                 Green;
    logic [7:0]                 Blue;
    logic                       hit;
    logic [IDX_W-1:0]           hit_idx;

    // pending (driven) and shadow (model of latched) object state
    int p_x [NUM_OBJ];
    int p_y [NUM_OBJ];
    int p_s [NUM_OBJ];
    int p_sh[NUM_OBJ];
    int p_en[NUM_OBJ];
    int s_x [NUM_OBJ];
    int s_y [NUM_OBJ];
    int s_s [NUM_OBJ];
    int s_sh[NUM_OBJ];
    int s_en[NUM_OBJ];

    logic [23:0] pal [0:7] = '{24'hFF5500, 24'h00FF55, 24'h5500FF, 24'hFFFF00,
                               24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h808080};

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_obj_color_mapper #(
        .NUM_OBJ (NUM_OBJ),
        .COORD_W (COORD_W),
        .SIZE_W  (SIZE_W)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_size    (obj_size),
        .obj_shape   (obj_shape),
        .obj_en      (obj_en),
        .pixel_valid (pixel_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .out_valid   (out_valid),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        obj_x     = '0;
        obj_y     = '0;
        obj_size  = '0;
        obj_shape = '0;
        obj_en    = '0;
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            obj_x[i*COORD_W +: COORD_W] = COORD_W'(p_x[i]);
            obj_y[i*COORD_W +: COORD_W] = COORD_W'(p_y[i]);
            obj_size[i*SIZE_W +: SIZE_W] = SIZE_W'(p_s[i]);
            obj_shape[i] = 1'(p_sh[i]);
            obj_en[i]    = 1'(p_en[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   bx;
        int   dx;
        int   dy;
        int   ax;
        int   ay;
        bit   cov;
        e.cyc = 0;
        e.hit = 1'b0;
        e.idx = '0;
        e.r   = 8'h00;
        e.g   = 8'h00;
        bx    = x >> 3;
        e.b   = (bx > 127) ? 8'h00 : 8'(127 - bx);
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (s_en[i] != 0) begin
                dx  = x - s_x[i];
                dy  = y - s_y[i];
                ax  = (dx < 0) ? -dx : dx;
                ay  = (dy < 0) ? -dy : dy;
                cov = (s_sh[i] != 0) ? (ax <= s_s[i] && ay <= s_s[i])
                                     : (dx*dx + dy*dy <= s_s[i]*s_s[i]);
                if (cov) begin
                    e.hit = 1'b1;
                    e.idx = 2'(i);
                    {e.r, e.g, e.b} = pal[i];
                end
            end
        end
        return e;
    endfunction

    task automatic set_obj(input int i, input int x, input int y, input int s,
                           input int sh, input int en);
        p_x[i] = x; p_y[i] = y; p_s[i] = s; p_sh[i] = sh; p_en[i] = en;
    endtask

    // One input cycle; a pixel in a frame_start cycle is predicted with the old shadow
    task automatic drive(input bit pv, input int x, input int y, input bit fs);
        exp_t e;
        @(negedge Clk);
        pixel_valid = pv;
        DrawX       = COORD_W'(x);
        DrawY       = COORD_W'(y);
        frame_start = fs;
        if (pv) begin
            e     = model(x, y);
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (fs) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                s_x[i] = p_x[i]; s_y[i] = p_y[i]; s_s[i] = p_s[i];
                s_sh[i] = p_sh[i]; s_en[i] = p_en[i];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic pix(input int x, input int y);
        drive(1'b1, x, y, 1'b0);
        idle(1);
    endtask

    task automatic frame();
        drive(1'b0, 0, 0, 1'b1);
        idle(1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            s_x[i] = 0; s_y[i] = 0; s_s[i] = 0; s_sh[i] = 0; s_en[i] = 0;
        end
    endtask

    // Monitor: compare every emerging pixel against the scoreboard head
    always @(posedge Clk) begin
        exp_t e;
        #1;
        cyc++;
        if (Reset_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("latency", 32'(cyc - e.cyc), 32'(LAT));
                    check_eq("hit", 32'(hit), 32'(e.hit));
                    check_eq("hit_idx", 32'(hit_idx), 32'(e.idx));
                    check_eq("rgb", {8'h00, Red, Green, Blue}, {8'h00, e.r, e.g, e.b});
                end
            end else if (sb.size() > 0 && (cyc - sb[0].cyc) > LAT) begin
                check_eq("missing_valid", 32'(out_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        for (int i = 0; i < int'(NUM_OBJ); i++) set_obj(i, 0, 0, 0, 0, 0);
        clear_model();
        repeat (3) @(negedge Clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
        check_eq("rst_hit", {31'd0, hit}, 32'd0);
        check_eq("rst_idx", 32'(hit_idx), 32'd0);
        Reset_n = 1'b1;
        idle(2);

        // circle hit on the rim, then the corner outside the radius
        set_obj(0, 320, 240, 4, 0, 1);
        frame();
        pix(324, 240);
        pix(320, 240);
        pix(323, 243);
        // square covers the same corner
        set_obj(0, 320, 240, 4, 1, 1);
        frame();
        pix(323, 243);
        pix(325, 240);

        // priority: obj0 and obj2 overlap, then obj0 disabled
        set_obj(0, 100, 100, 5, 0, 1);
        set_obj(2, 102, 101, 3, 1, 1);
        frame();
        pix(100, 100);
        set_obj(0, 100, 100, 5, 0, 0);
        frame();
        pix(100, 100);

        // object moves only at frame_start; pixel in that cycle uses the old position
        set_obj(0, 200, 100, 2, 0, 1);
        pix(200, 100);
        drive(1'b1, 200, 100, 1'b1);
        drive(1'b1, 200, 100, 1'b0);
        idle(1);

        // background gradient extremes and exact-centre objects of size 0
        pix(1023, 0);
        pix(0, 0);
        set_obj(1, 500, 400, 0, 0, 1);
        set_obj(3, 600, 400, 0, 1, 1);
        frame();
        pix(500, 400);
        pix(501, 400);
        pix(500, 401);
        pix(600, 400);
        pix(601, 401);

        // object hanging off the top-left corner
        set_obj(0, 2, 3, 5, 0, 1);
        frame();
        pix(0, 0);
        pix(1023, 1023);

        // back-to-back random stream with frame updates mid-stream
        for (int k = 0; k < 80; k++) begin
            if (k % 20 == 0) begin
                for (int i = 0; i < int'(NUM_OBJ); i++)
                    set_obj(i, int'($urandom_range(60, 140)), int'($urandom_range(60, 140)),
                            int'($urandom_range(0, 30)), int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 3) != 0));
            end
            drive(1'b1, int'($urandom_range(40, 160)), int'($urandom_range(40, 160)),
                  (k % 20 == 5));
        end
        idle(1);

        // reset in the middle of a stream drops everything in flight
        for (int k = 0; k < 4; k++) drive(1'b1, 100 + k, 100, 1'b0);
        @(negedge Clk);
        Reset_n     = 1'b0;
        pixel_valid = 1'b0;
        sb.delete();
        clear_model();
        #1;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
        check_eq("midrst_hit", {31'd0, hit}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);
        for (int k = 0; k < 5; k++) drive(1'b1, 100 + k, 100, 1'b0);
        idle(6);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1);
    end

endmodule
